// File: rtl/shift_add_mult_pkg.sv
// Shared definitions for the shift-and-add multiplier: default operand width
// and the control FSM state encoding.
package mult_pkg;

   localparam int DEFAULT_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/shift_add_mult_csa.sv
// Carry-select adder: the low half ripples, the high half is computed for both
// carry-in values and the low-half carry picks the right one.
module CSA #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   output logic [WIDTH-1:0] sum,
   output logic             co
);

   localparam int LO = WIDTH / 2;
   localparam int HI = WIDTH - LO;

   logic [LO:0] lowSum;
   logic [HI:0] highSum0;
   logic [HI:0] highSum1;

   always_comb begin
      lowSum   = {1'b0, a[LO-1:0]} + {1'b0, b[LO-1:0]} + {{LO{1'b0}}, ci};
      highSum0 = {1'b0, a[WIDTH-1:LO]} + {1'b0, b[WIDTH-1:LO]};
      highSum1 = {1'b0, a[WIDTH-1:LO]} + {1'b0, b[WIDTH-1:LO]} + {{HI{1'b0}}, 1'b1};
      if (lowSum[LO]) begin
         sum = {highSum1[HI-1:0], lowSum[LO-1:0]};
         co  = highSum1[HI];
      end else begin
         sum = {highSum0[HI-1:0], lowSum[LO-1:0]};
         co  = highSum0[HI];
      end
   end

endmodule

// File: rtl/shift_add_mult.sv
// Sequential unsigned shift-and-add multiplier: one multiplier bit per clock,
// using the CSA as the partial-product adder, registered product with a done strobe.
module shift_add_mult
   import mult_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   state_t             state_q, state_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [2*WIDTH-1:0] product_q, product_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [CW-1:0]      cnt_q, cnt_d;

   logic [WIDTH-1:0]   addend;
   logic [WIDTH-1:0]   csaSum;
   logic               csaCo;
   logic [2*WIDTH-1:0] accShift;

   // Upper half of acc accumulates; the carry is kept by shifting it into the MSB.
   assign addend   = acc_q[0] ? mcand_q : '0;
   assign accShift = {csaCo, csaSum, acc_q[WIDTH-1:1]};

   CSA #(.WIDTH(WIDTH)) u_csa (
      .a   (acc_q[2*WIDTH-1:WIDTH]),
      .b   (addend),
      .ci  (1'b0),
      .sum (csaSum),
      .co  (csaCo)
   );

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      mcand_d   = mcand_q;
      cnt_d     = cnt_q;
      product_d = product_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               mcand_d = a;
               acc_d   = {{WIDTH{1'b0}}, b};
               cnt_d   = '0;
            end
         end
         RUN: begin
            acc_d = accShift;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST_CNT) begin
               state_d   = DONE;
               product_d = accShift;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         acc_q     <= '0;
         mcand_q   <= '0;
         cnt_q     <= '0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         mcand_q   <= mcand_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
      end
   end

   assign busy    = (state_q == RUN) || (state_q == DONE);
   assign done    = (state_q == DONE);
   assign product = product_q;

endmodule

// File: tb/tb_shift_add_mult.sv
// Directed and exhaustive bench for shift_add_mult (WIDTH=4); a scoreboard queue
// holds expected products and a monitor checks them whenever done is seen.
module tb_shift_add_mult;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [2*W-1:0] product;

   int compared   = 0;
   int mismatched = 0;
   int doneCount  = 0;
   int cycleCnt   = 0;
   logic [2*W-1:0] sbQ[$];
   logic [2*W-1:0] expVal;

   shift_add_mult #(.WIDTH(W)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .product (product)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycleCnt++;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Monitor: every done cycle pops the oldest expected product and compares.
   always @(negedge clk) begin
      if (reset === 1'b0 && done === 1'b1) begin
         doneCount++;
         if (sbQ.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL unexpected_done: got product 0x%0h, expected no done", product);
         end else begin
            expVal = sbQ.pop_front();
            checkOutput("product", {24'b0, product}, {24'b0, expVal});
         end
      end
   end

   // Issue one start pulse; the expected product is pushed only when the start will be accepted.
   task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv,
                                input logic push, input logic [2*W-1:0] expP);
      @(posedge clk);
      #1;
      start = 1'b1;
      a     = av;
      b     = bv;
      if (push) sbQ.push_back(expP);
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic waitDone(input string name);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (done !== 1'b1 && n < 40);
      if (done !== 1'b1) checkOutput({name, "_timeout"}, {31'b0, done}, 32'd1);
   endtask

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int lat, busyCnt, t1, t2, base, mmBefore;
      logic loopRan;
      logic [2*W-1:0] prodVal;

      // Reset with start held high must not launch an operation.
      reset = 1'b1;
      start = 1'b1;
      a     = 4'hF;
      b     = 4'hF;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_busy", {31'b0, busy}, 32'd0);
      checkOutput("reset_done", {31'b0, done}, 32'd0);
      checkOutput("reset_product", {24'b0, product}, 32'h00);
      reset = 1'b0;
      start = 1'b0;
      @(negedge clk);
      checkOutput("no_start_after_reset", {31'b0, busy}, 32'd0);

      // 15 x 15: latency and busy width.
      applyStimulus(4'hF, 4'hF, 1'b1, 8'hE1);
      lat     = 0;
      busyCnt = 0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (done === 1'b1 && lat == 0) lat = i;
         if (busy === 1'b1) busyCnt++;
      end
      checkOutput("latency_15x15", lat, 32'd5);
      checkOutput("busy_cycles_15x15", busyCnt, 32'd5);

      // 13 x 11 then 0 x 9 with start held high.
      @(posedge clk);
      #1;
      start = 1'b1;
      a     = 4'd13;
      b     = 4'd11;
      sbQ.push_back(8'h8F);
      sbQ.push_back(8'h00);
      @(posedge clk);
      #1;
      a = 4'd0;
      b = 4'd9;
      repeat (5) @(negedge clk);
      checkOutput("first_done_b2b", {31'b0, done}, 32'd1);
      t1 = cycleCnt;
      @(negedge clk);
      checkOutput("hold_8f", {24'b0, product}, 32'h8F);
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checkOutput("hold_8f", {24'b0, product}, 32'h8F);
      end
      waitDone("second_done_b2b");
      t2 = cycleCnt;
      checkOutput("done_gap_b2b", t2 - t1, 32'd6);

      // Start during RUN is ignored.
      repeat (2) @(posedge clk);
      base = doneCount;
      applyStimulus(4'd3, 4'd5, 1'b1, 8'h0F);
      @(posedge clk);
      #1;
      start = 1'b1;
      a     = 4'd7;
      b     = 4'd7;
      @(posedge clk);
      #1;
      start = 1'b0;
      waitDone("done_3x5");
      repeat (10) @(posedge clk);
      checkOutput("single_done_ignored_start", doneCount - base, 32'd1);
      checkOutput("product_after_ignored", {24'b0, product}, 32'h0F);

      // Reset on the second RUN cycle aborts the operation.
      applyStimulus(4'd9, 4'd9, 1'b1, 8'h51);
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkOutput("abort_busy", {31'b0, busy}, 32'd0);
      checkOutput("abort_done", {31'b0, done}, 32'd0);
      checkOutput("abort_product", {24'b0, product}, 32'h00);
      reset = 1'b0;
      sbQ.delete();
      base = doneCount;
      repeat (8) @(posedge clk);
      checkOutput("no_done_after_abort", doneCount - base, 32'd0);
      applyStimulus(4'd2, 4'd3, 1'b1, 8'h06);
      waitDone("done_2x3");

      // All 256 operand pairs.
      repeat (2) @(posedge clk);
      base     = doneCount;
      mmBefore = mismatched;
      loopRan  = 1'b0;
      for (int ai = 0; ai < 16; ai++) begin
         for (int bi = 0; bi < 16; bi++) begin
            prodVal = 8'(ai) * 8'(bi);
            applyStimulus(4'(ai), 4'(bi), 1'b1, prodVal);
            waitDone("done_exhaustive");
            loopRan = 1'b1;
         end
      end
      repeat (3) @(posedge clk);
      checkOutput("exhaustive_loop_ran", {31'b0, loopRan}, 32'd1);
      checkOutput("exhaustive_done_count", doneCount - base, 32'd256);
      checkOutput("exhaustive_pass", {31'b0, (mismatched == mmBefore)}, 32'd1);
      checkOutput("scoreboard_drained", sbQ.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/shift_add_mult.md
# shift_add_mult

Sequential unsigned shift-and-add multiplier built around the existing `CSA` adder. It sits directly downstream of `CSA` and uses it as the per-cycle partial-product adder. It accepts two `WIDTH`-bit operands on a start pulse, iterates one multiplier bit per clock, and presents a registered `2*WIDTH`-bit product with a one-cycle `done` strobe. This is the next lab stage after the combinational adder: the same arithmetic, now under a clocked control FSM.

## Interface
- `WIDTH`, default 4: operand width; product is `2*WIDTH` bits; legal range 2..16.

- `clk`  in  1  system clock, rising-edge active
- `reset`  in  1  synchronous, active-high; sampled on the rising edge of `clk`
- `start`  in  1  request; sampled only in state IDLE
- `a`  in  WIDTH  multiplicand, unsigned, captured on an accepted start
- `b`  in  WIDTH  multiplier, unsigned, captured on an accepted start
- `busy`  out  1  high in states RUN and DONE
- `done`  out  1  high for exactly one cycle, in state DONE
- `product`  out  2*WIDTH  last completed result, registered

## Operation
- FSM states:
  - IDLE: if `start`=1, go to RUN.
  - RUN: stay for exactly WIDTH cycles, then go to DONE.
  - DONE: go to IDLE unconditionally (one cycle).
- Accepted start (IDLE and `start`=1):
  - `mcand`←`a`; `acc`←{WIDTH'b0, `b`}; `cnt`←0.
- Each RUN cycle:
  - The `CSA` computes {co,sum} = `acc[2W-1:W]` + (`acc[0]` ? `mcand` : 0), with ci=0.
  - `acc`←{co, sum, `acc[W-1:1]`}, a logical right shift by 1 that keeps the carry.
  - `cnt`←`cnt`+1.
- Leaving RUN (`cnt` = WIDTH-1): `product`←the shifted `acc` value.
- `product` changes only on that edge and on reset; it holds its value through IDLE and later RUN phases.
- `start` is ignored in RUN and DONE. No queuing, no error flag.
- `a` and `b` are don't-care outside the accept edge. Changing them during RUN has no effect.
- Width rules:
  - The sum never exceeds `2*WIDTH` bits. The maximum is (2^W-1)^2 < 2^(2W), so there is no overflow output.
  - `cnt` is clog2(WIDTH)+1 bits wide.

## Timing
- Reset values: state=IDLE, `busy`=0, `done`=0, `product`=0, `acc`=0, `mcand`=0, `cnt`=0.
- Reset has priority over every other event, including a `start` on the same edge. A reset during RUN or DONE aborts the operation; no `done` is produced.
- Latency: start sampled on edge k → RUN on edges k+1..k+WIDTH → `done`=1 and `product` valid during the cycle after edge k+WIDTH. That is WIDTH+1 cycles from start to done.
- Throughput: one product every WIDTH+2 cycles. A new start is accepted no earlier than the edge after DONE.
- `busy` rises on the cycle after the accept edge and falls with `done`.
- `start` held high continuously re-triggers back-to-back, once per IDLE visit.
- `busy`, `done` and `product` are registered or decoded directly from the state register. There is no combinational path from inputs to outputs.

## Structure
- Shared package/include `mult_pkg`:
  - state encoding localparams IDLE=2'd0, RUN=2'd1, DONE=2'd2
  - default `WIDTH`
- Unused encoding 2'd3 returns to IDLE.
- Sub-module: one `CSA #(WIDTH)` instance for the partial-product add; its internals are unchanged.
- Everything else (FSM, `acc` shift register, `cnt` counter) lives in `shift_add_mult`. Target size: roughly 150 lines.

## Test plan
All directed scenarios use WIDTH=4.

1. Reset: assert `reset` for 2 cycles with `start`=1 → `busy`=0, `done`=0, `product`=8'h00; no operation starts.
2. 15×15: pulse `start` with a=4'hF, b=4'hF.
   - `done`=1 exactly 5 cycles after the start edge.
   - `product`=8'hE1.
   - `busy`=1 for 5 cycles.
3. 13×11 then 0×9, back-to-back with `start` held high:
   - first done → `product`=8'h8F;
   - second done, 6 cycles later → `product`=8'h00;
   - between the two dones, `product` holds 8'h8F.
4. Start during busy: accept 3×5, then pulse `start` with a=7, b=7 during RUN → exactly one `done`, `product`=8'h0F.
5. Reset mid-operation: start 9×9 and assert `reset` on the 2nd RUN cycle → `busy`=0 next cycle, no `done`, `product`=8'h00. A following 2×3 gives 8'h06.
6. Exhaustive: all 256 (a,b) pairs, each checked against a*b at `done`; the bench tracks a pass/fail flag. It also verifies a "loop executed" flag so an empty loop cannot report pass.
